serial_deserializer: RTL and testbench

Receive-side counterpart of the 4-bit load/shift serializer path: samples a serial bit stream on a bit strobe, uses a load marker to find word boundaries, and presents each completed word as a parallel value held under a valid/ack handshake. It sits between a serial link and parallel consumers such as LED banks, registers and counters. It also reports framing errors and overruns.

---
 rtl/serial_deserializer.sv | 100 ++++++++++
 tb/tb_serial_deserializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word receiver: load-marked framing, valid/ack word handoff,
// framing-error pulse and sticky overrun flag. All outputs are registered.
module serial_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           input_clock1_clk_1,
  input  logic                           input_push_button1_reset_1,
  input  logic                           serial_in,
  input  logic                           bit_strobe,
  input  logic                           load,
  input  logic                           word_ack,
  output logic [WIDTH-1:0]               word_out,
  output logic                           word_valid,
  output logic                           frame_error,
  output logic                           overrun,
  output logic [$clog2(WIDTH+1)-1:0]     bit_count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;
  logic             fe_q;
  logic             ovr_q;

  logic [WIDTH-1:0] asm_d;
  logic [CW-1:0]    cnt_d;
  logic             start_d;
  logic             cont_d;
  logic             abort_d;
  logic             done_d;

  // MSB-first shifts toward the top so the first bit ends at WIDTH-1; LSB-first mirrors it.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r    = w << 1;
      r[0] = b;
    end else begin
      r          = w >> 1;
      r[WIDTH-1] = b;
    end
    return r;
  endfunction

  always_comb begin
    start_d = bit_strobe & load;
    cont_d  = bit_strobe & ~load & (state_q == SHIFT);
    abort_d = start_d & (state_q == SHIFT);
    asm_d   = shift_in(start_d ? '0 : shift_q, serial_in);
    cnt_d   = start_d ? CW'(1) : cnt_q + CW'(1);
    done_d  = (start_d | cont_d) & (cnt_d == FULL);
  end

  always_ff @(posedge input_clock1_clk_1) begin
    if (input_push_button1_reset_1) begin
      state_q <= IDLE;
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      fe_q <= abort_d;
      if (done_d) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (start_d | cont_d) begin
        state_q <= SHIFT;
        cnt_q   <= cnt_d;
        shift_q <= asm_d;
      end
      // A completed word is only taken when the output slot is free or being freed now.
      if (done_d && (!valid_q || word_ack)) begin
        word_q  <= asm_d;
        valid_q <= 1'b1;
      end else if (done_d) begin
        ovr_q <= 1'b1;
      end else if (valid_q && word_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign frame_error = fe_q;
  assign overrun     = ovr_q;
  assign bit_count   = cnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: three instances (W4 MSB-first, W4 LSB-first, W1)
// share one stimulus stream; a bit-list reference model feeds per-instance scoreboards.
module tb_serial_deserializer;

  logic clk = 1'b0;
  logic rst, serial_in, bit_strobe, load, word_ack;

  logic [3:0] w0, w1;
  logic [0:0] w2;
  logic [2:0] bc0, bc1;
  logic [0:0] bc2;
  logic v0, v1, v2, f0, f1, f2, o0, o1, o2;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .input_clock1_clk_1(clk), .input_push_button1_reset_1(rst), .serial_in(serial_in),
    .bit_strobe(bit_strobe), .load(load), .word_ack(word_ack), .word_out(w0),
    .word_valid(v0), .frame_error(f0), .overrun(o0), .bit_count(bc0));

  serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .input_clock1_clk_1(clk), .input_push_button1_reset_1(rst), .serial_in(serial_in),
    .bit_strobe(bit_strobe), .load(load), .word_ack(word_ack), .word_out(w1),
    .word_valid(v1), .frame_error(f1), .overrun(o1), .bit_count(bc1));

  serial_deserializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .input_clock1_clk_1(clk), .input_push_button1_reset_1(rst), .serial_in(serial_in),
    .bit_strobe(bit_strobe), .load(load), .word_ack(word_ack), .word_out(w2),
    .word_valid(v2), .frame_error(f2), .overrun(o2), .bit_count(bc2));

  logic [15:0] wout [3];
  logic [15:0] cnt  [3];
  logic        vld [3], fe [3], ov [3];
  assign wout[0] = {12'd0, w0};
  assign wout[1] = {12'd0, w1};
  assign wout[2] = {15'd0, w2};
  assign cnt[0]  = {13'd0, bc0};
  assign cnt[1]  = {13'd0, bc1};
  assign cnt[2]  = {15'd0, bc2};
  assign vld[0] = v0; assign vld[1] = v1; assign vld[2] = v2;
  assign fe[0]  = f0; assign fe[1]  = f1; assign fe[2]  = f2;
  assign ov[0]  = o0; assign ov[1]  = o1; assign ov[2]  = o2;

  localparam int WID [3] = '{4, 4, 1};
  localparam bit MSB [3] = '{1'b1, 1'b0, 1'b1};

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(string name, int inst, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d got=%h want=%h at %0t", name, inst, act, exp, $time);
  endfunction

  // Reference model: collects bits into a list, builds the word by weighting each bit
  // by its arrival position, then applies the handoff rules.
  bit          coll [3];
  int          nb   [3];
  bit          bits [3][16];
  bit          vm [3], fm [3], om [3];
  logic [15:0] wm [3];
  logic [15:0] exp_q [3][$];
  bit          armed = 1'b0;
  bit          m_done;
  logic [15:0] m_word;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        coll[i] = 1'b0; nb[i] = 0; vm[i] = 1'b0; fm[i] = 1'b0; om[i] = 1'b0; wm[i] = '0;
        exp_q[i].delete();
      end else begin
        m_done = 1'b0;
        m_word = '0;
        fm[i]  = 1'b0;
        if (bit_strobe) begin
          if (load) begin
            if (coll[i]) fm[i] = 1'b1;
            coll[i] = 1'b1;
            nb[i]   = 0;
          end
          if (coll[i]) begin
            bits[i][nb[i]] = serial_in;
            nb[i]++;
          end
          if (coll[i] && nb[i] == WID[i]) begin
            for (int j = 0; j < WID[i]; j++)
              m_word = m_word | (16'(bits[i][j]) << (MSB[i] ? WID[i] - 1 - j : j));
            m_done  = 1'b1;
            coll[i] = 1'b0;
            nb[i]   = 0;
          end
        end
        if (m_done && (!vm[i] || word_ack)) begin
          wm[i] = m_word;
          vm[i] = 1'b1;
          exp_q[i].push_back(m_word);
        end else if (m_done) begin
          om[i] = 1'b1;
        end else if (vm[i] && word_ack) begin
          vm[i] = 1'b0;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  // Monitor: per-cycle flag checks, and a scoreboard pop whenever a fresh word appears.
  bit   vprev [3];
  logic ack_prev = 1'b0;
  logic [15:0] popped;

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        check("valid", i, {15'd0, vld[i]}, {15'd0, vm[i]});
        check("frame_error", i, {15'd0, fe[i]}, {15'd0, fm[i]});
        check("overrun", i, {15'd0, ov[i]}, {15'd0, om[i]});
        check("bit_count", i, cnt[i], 16'(nb[i]));
        if (vm[i]) check("word_hold", i, wout[i], wm[i]);
        if (vld[i] && (!vprev[i] || ack_prev)) begin
          if (exp_q[i].size() == 0) check("sb_unexpected", i, 16'(exp_q[i].size()), 16'd1);
          else begin
            popped = exp_q[i].pop_front();
            check("sb_word", i, wout[i], popped);
          end
        end
        vprev[i] = vld[i];
      end
      ack_prev = word_ack;
    end
  end

  task automatic cyc(input logic r, input logic s, input logic b, input logic l, input logic a);
    rst = r; serial_in = s; bit_strobe = b; load = l; word_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b0; bit_strobe = 1'b0; load = 1'b0; word_ack = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_word", 0, wout[0], 16'h0);
    check("rst_valid", 0, {15'd0, vld[0]}, 16'h0);
    check("rst_count", 0, cnt[0], 16'h0);

    // 1,0,1,1 with load on the first bit
    cyc(0, 1, 1, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0);
    check("plan_msb_word", 0, wout[0], 16'h000B);
    check("plan_msb_valid", 0, {15'd0, vld[0]}, 16'h1);
    check("plan_msb_fe", 0, {15'd0, fe[0]}, 16'h0);
    check("plan_lsb_word", 1, wout[1], 16'h000D);
    cyc(0, 0, 0, 0, 1);
    check("plan_ack_clears", 1, {15'd0, vld[1]}, 16'h0);

    // Frame abort: restart on the third strobe
    cyc(0, 1, 1, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0);
    check("plan_abort_fe", 0, {15'd0, fe[0]}, 16'h1);
    cyc(0, 1, 1, 0, 0);
    check("plan_abort_fe_once", 0, {15'd0, fe[0]}, 16'h0);
    cyc(0, 1, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    check("plan_abort_word", 0, wout[0], 16'h0006);
    cyc(0, 0, 0, 0, 1);

    // Overrun, then completion coinciding with ack
    cyc(0, 1, 1, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 1, 1, 0, 0);
    check("plan_ovr_word", 0, wout[0], 16'h000A);
    check("plan_ovr_flag", 0, {15'd0, ov[0]}, 16'h1);
    cyc(0, 1, 1, 1, 0); cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 1, 1, 0, 1);
    check("plan_ackcomp_word", 0, wout[0], 16'h000F);
    check("plan_ackcomp_valid", 0, {15'd0, vld[0]}, 16'h1);
    check("plan_ackcomp_ovr", 0, {15'd0, ov[0]}, 16'h1);

    // Hunting, mid-word reset, fresh frame
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 1, 1, 0, 0);
    check("plan_hunt_count", 0, cnt[0], 16'h0);
    check("plan_hunt_valid", 0, {15'd0, vld[0]}, 16'h0);
    cyc(0, 1, 1, 1, 0);
    check("plan_w1_word", 2, wout[2], 16'h1);
    check("plan_w1_valid", 2, {15'd0, vld[2]}, 16'h1);
    cyc(0, 0, 1, 0, 0);
    check("plan_partial_count", 0, cnt[0], 16'h2);
    cyc(1, 1, 1, 0, 0);
    check("plan_rst_count", 0, cnt[0], 16'h0);
    check("plan_rst_valid", 2, {15'd0, vld[2]}, 16'h0);
    cyc(0, 1, 1, 1, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
    check("plan_fresh_word", 0, wout[0], 16'h000C);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) < 4));
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) check("sb_drain", i, 16'(exp_q[i].size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
